// File: rtl/array_serializer.sv
// array_serializer: captures a whole DEPTH-element array in one handshake and
// replays it one element per transfer on a valid/ready stream, tagging each
// element with its unpacked index and flagging the final element.
//
// Build option: define ARRAY_SER_MSB_FIRST_EN to emit elements from index
// DEPTH-1 down to 0. The default build emits index 0 up to DEPTH-1. Ports,
// latency and handshake behaviour are identical in both builds.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. A source holding valid=1 keeps its payload stable
// until that transfer. in_ready depends only on FSM state, never on in_valid,
// and out_valid/out_data/out_idx/out_last depend only on registered state,
// never on out_ready, so there is no combinational path through the block.
module array_serializer #(
  parameter int ELEM_W = 4,
  parameter int DEPTH  = 4,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data [DEPTH-1:0],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  // Element ordering: where a new array starts, where it ends, and which way
  // the counter walks between them.
`ifdef ARRAY_SER_MSB_FIRST_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] FINAL_IDX = '0;
  localparam logic             STEP_UP   = 1'b0;
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] FINAL_IDX = IDX_W'(DEPTH - 1);
  localparam logic             STEP_UP   = 1'b1;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // FSM state is kept as a named signal so checkers can bind to it directly.
  state_t state;
  state_t next_state;

  // Datapath storage: the captured array and the index of the element on show.
  logic [ELEM_W-1:0] captured [DEPTH-1:0];
  logic [IDX_W-1:0]  counter;

  // Control strobes produced by the FSM for the datapath.
  logic load_array;
  logic advance;
  logic at_final;

  assign at_final = (counter == FINAL_IDX);

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load_array = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_array = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (at_final) begin
            // Final element leaves; one bubble cycle in IDLE before next accept.
            next_state = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Array capture: written only on an IDLE accept, so input changes while
  // sending cannot disturb the elements still to be emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        captured[i] <= '0;
      end
    end else if (load_array) begin
      for (int i = 0; i < DEPTH; i++) begin
        captured[i] <= in_data[i];
      end
    end
  end

  // Element counter: loads the first index on accept, steps on each
  // non-final transfer, and holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
    end else if (load_array) begin
      counter <= FIRST_IDX;
    end else if (advance) begin
      if (STEP_UP) begin
        counter <= counter + IDX_W'(1);
      end else begin
        counter <= counter - IDX_W'(1);
      end
    end
  end

  // Output payload: zeroed whenever no element is being offered.
  always_comb begin
    out_data = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_data = captured[counter];
      out_idx  = counter;
      out_last = at_final;
    end
  end

endmodule

// File: tb/tb_array_serializer.sv
// tb_array_serializer: directed cycle table for the documented scenarios
// (stream order, stall, input changes while sending, reset mid-array,
// back-to-back arrays) followed by randomized traffic checked against a
// queue-based reference model. Works for either element-order build.
module tb_array_serializer;

  localparam int ELEM_W = 4;
  localparam int DEPTH  = 4;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int W      = 1 + IDX_W + ELEM_W;  // {last, idx, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data [DEPTH-1:0];
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  array_serializer #(.ELEM_W(ELEM_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  // Position k of the emitted stream maps to this unpacked index.
  function automatic int idx_of(input int k);
`ifdef ARRAY_SER_MSB_FIRST_EN
    return DEPTH - 1 - k;
`else
    return k;
`endif
  endfunction

  function automatic logic [ELEM_W-1:0] elem(input logic [15:0] arr, input int i);
    return arr[i*ELEM_W +: ELEM_W];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic iv, input logic [15:0] din, input logic ordy);
    rst       = r;
    in_valid  = iv;
    out_ready = ordy;
    for (int i = 0; i < DEPTH; i++) in_data[i] = elem(din, i);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic              rst;
    logic              iv;
    logic [15:0]       din;
    logic              ordy;
    logic              e_in_ready;
    logic              e_valid;
    logic [ELEM_W-1:0] e_data;
    logic [IDX_W-1:0]  e_idx;
    logic              e_last;
  } vec_t;

  vec_t vecs[$];

  // k < 0: block expected idle this cycle; else showing stream position k of arr.
  task automatic add(input logic r, input logic iv, input logic [15:0] din,
                     input logic ordy, input int k, input logic [15:0] arr);
    vec_t v;
    v.rst  = r;
    v.iv   = iv;
    v.din  = din;
    v.ordy = ordy;
    if (k < 0) begin
      v.e_in_ready = 1'b1;
      v.e_valid    = 1'b0;
      v.e_data     = '0;
      v.e_idx      = '0;
      v.e_last     = 1'b0;
    end else begin
      v.e_in_ready = 1'b0;
      v.e_valid    = 1'b1;
      v.e_data     = elem(arr, idx_of(k));
      v.e_idx      = IDX_W'(idx_of(k));
      v.e_last     = (k == DEPTH - 1);
    end
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard (reference model) ----------------
  logic [W-1:0] exp_q[$];

  task automatic model_check(input int cyc);
    logic [W-1:0] f;
    check($sformatf("rnd_in_ready c%0d", cyc), 32'(in_ready), 32'(exp_q.size() == 0));
    check($sformatf("rnd_out_valid c%0d", cyc), 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      f = exp_q[0];
      check($sformatf("rnd_out_data c%0d", cyc), 32'(out_data), 32'(f[ELEM_W-1:0]));
      check($sformatf("rnd_out_idx c%0d", cyc), 32'(out_idx), 32'(f[ELEM_W +: IDX_W]));
      check($sformatf("rnd_out_last c%0d", cyc), 32'(out_last), 32'(f[W-1]));
    end else begin
      check($sformatf("rnd_idle_payload c%0d", cyc), {out_last, out_idx, out_data}, 32'(0));
    end
  endtask

  task automatic model_step(input logic r, input logic iv, input logic [15:0] din, input logic ordy);
    logic [W-1:0] e;
    if (r) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (iv) begin
        for (int k = 0; k < DEPTH; k++) begin
          e = {(k == DEPTH - 1), IDX_W'(idx_of(k)), elem(din, idx_of(k))};
          exp_q.push_back(e);
        end
      end
    end else if (ordy) begin
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- main sequence ----------------
  localparam logic [15:0] ARR1  = 16'hDCBA;  // in_data[0]=A .. in_data[3]=D
  localparam logic [15:0] ARR2  = 16'h4321;  // in_data[0]=1 .. in_data[3]=4
  localparam logic [15:0] NINES = 16'h9999;

  initial begin
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    next_cycle();
    next_cycle();

    // Reset held, then released: idle outputs.
    add(1, 0, 0, 0, -1, 0);
    add(0, 0, 0, 0, -1, 0);
    // Plain stream with out_ready held high, bubble after last.
    add(0, 1, ARR1, 1, -1, 0);
    for (int k = 0; k < DEPTH; k++) add(0, 0, 0, 1, k, ARR1);
    add(0, 0, 0, 0, -1, 0);
    // Stall for 3 cycles on the second element; inputs change while sending.
    add(0, 1, ARR1, 1, -1, 0);
    add(0, 1, NINES, 1, 0, ARR1);
    add(0, 1, NINES, 0, 1, ARR1);
    add(0, 1, NINES, 0, 1, ARR1);
    add(0, 1, NINES, 0, 1, ARR1);
    add(0, 1, NINES, 1, 1, ARR1);
    add(0, 1, NINES, 1, 2, ARR1);
    add(0, 0, 0, 1, 3, ARR1);
    add(0, 0, 0, 1, -1, 0);
    // Reset while showing the third element, with in_valid/out_ready also high.
    add(0, 1, ARR1, 1, -1, 0);
    add(0, 0, 0, 1, 0, ARR1);
    add(0, 0, 0, 1, 1, ARR1);
    add(1, 1, ARR1, 1, 2, ARR1);
    add(0, 1, ARR2, 1, -1, 0);
    for (int k = 0; k < DEPTH; k++) add(0, 0, 0, 1, k, ARR2);
    add(0, 0, 0, 0, -1, 0);
    // Back-to-back arrays with in_valid held high.
    add(0, 1, ARR1, 1, -1, 0);
    for (int k = 0; k < DEPTH - 1; k++) add(0, 1, ARR1, 1, k, ARR1);
    add(0, 1, ARR2, 1, DEPTH - 1, ARR1);
    add(0, 1, ARR2, 1, -1, 0);
    for (int k = 0; k < DEPTH; k++) add(0, 0, 0, 1, k, ARR2);
    add(0, 0, 0, 0, -1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_in_ready));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d out_idx", i), 32'(out_idx), 32'(vecs[i].e_idx));
      check($sformatf("vec%0d out_last", i), 32'(out_last), 32'(vecs[i].e_last));
      next_cycle();
    end

    // Randomized traffic; the table leaves the block idle, matching an empty model.
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      logic        r;
      logic        iv;
      logic        ordy;
      logic [15:0] din;
      r    = ($urandom_range(0, 99) < 2);
      iv   = ($urandom_range(0, 99) < 50);
      ordy = ($urandom_range(0, 99) < 70);
      din  = 16'($urandom);
      drive(r, iv, din, ordy);
      model_check(c);
      model_step(r, iv, din, ordy);
      next_cycle();
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/array_serializer.md
ARRAY_SERIALIZER -- requirements
Module: array_serializer

Interface
REQ-001 SHALL have parameter ELEM_W, default 4, bit width of one array element.
REQ-002 SHALL have parameter DEPTH, default 4, number of elements in the input array (legal 2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  producer offers a full array.
REQ-006 SHALL have port in_ready  output  1  block can accept an array this cycle.
REQ-007 SHALL have port in_data  input  ELEM_W x [DEPTH-1:0] unpacked  array to serialize, one element per unpacked index.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid element.
REQ-009 SHALL have port out_ready  input  1  consumer accepts current element.
REQ-010 SHALL have port out_data  output  ELEM_W  current element.
REQ-011 SHALL have port out_idx  output  clog2(DEPTH)  unpacked index of current element.
REQ-012 SHALL have port out_last  output  1  current element is final element of the array.

Function
REQ-013 SHALL implement FSM states IDLE and SEND.
REQ-014 IDLE: SHALL drive in_ready=1, out_valid=0.
REQ-015 IDLE with in_valid=1: SHALL capture all DEPTH elements of in_data into an internal array register, load the element counter with the first index, and enter SEND next cycle.
REQ-016 SEND: SHALL drive in_ready=0, out_valid=1, out_data=captured[counter], out_idx=counter.
REQ-017 Latency: first out_valid SHALL assert exactly one cycle after the in_valid&in_ready cycle.
REQ-018 Transfer occurs on out_valid&out_ready; on a non-final transfer the counter SHALL advance by one index.
REQ-019 out_last SHALL be 1 only in SEND while counter equals the final index.
REQ-020 Transfer with out_last=1 SHALL return FSM to IDLE; in_ready=1 the following cycle (one bubble cycle between arrays).
REQ-021 out_valid=1 with out_ready=0: out_data, out_idx, out_last SHALL hold stable for any number of cycles.
REQ-022 Changes on in_data or in_valid during SEND SHALL be ignored; captured array SHALL not change until the next IDLE accept.
REQ-023 When out_valid=0, out_data and out_idx SHALL be driven to 0.
REQ-024 Each accepted array SHALL produce exactly DEPTH transfers; no element skipped or duplicated.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, counter=0, captured array=0, regardless of state.
REQ-026 During/after reset: in_ready=1 (after the reset edge), out_valid=0, out_data=0, out_idx=0, out_last=0.
REQ-027 Reset mid-SEND SHALL abort the array; remaining elements SHALL never be emitted.
REQ-028 rst SHALL take priority over simultaneous in_valid or out_ready.

Configuration
REQ-029 Macro ARRAY_SER_MSB_FIRST_EN SHALL select element order.
REQ-030 Without ARRAY_SER_MSB_FIRST_EN: first index 0, counter increments, final index DEPTH-1.
REQ-031 With ARRAY_SER_MSB_FIRST_EN: first index DEPTH-1, counter decrements, final index 0.
REQ-032 Interface, latency and handshake SHALL be identical in both builds.

Verification (ELEM_W=4, DEPTH=4, in_data[3..0]=D,C,B,A)
REQ-033 Accept array, out_ready held 1 -> out_data A,B,C,D on cycles 1..4 after accept, out_idx 0..3, out_last only on D, in_ready=1 on cycle 5.
REQ-034 Same with ARRAY_SER_MSB_FIRST_EN -> D,C,B,A, out_idx 3..0, out_last on A.
REQ-035 out_ready low 3 cycles while showing B -> B, idx 1 held stable all 3 cycles, then C follows; exactly 4 transfers total.
REQ-036 in_data changed to 9,9,9,9 with in_valid=1 during SEND -> outputs remain A,B,C,D; in_ready stays 0.
REQ-037 rst pulsed while showing C -> next cycle out_valid=0, out_data=0, in_ready=1; D never emitted; new array 1,2,3,4 then streams 1,2,3,4 (LSB-first build).
REQ-038 Back-to-back arrays with in_valid held 1 -> second array accepted on the cycle after first out_last transfer, first element out one cycle later.
